// File: rtl/store_v.sv
// store_v: drains tiles of ELEM_COUNT bytes into a byte-wide memory port.
// A transfer of `length` elements starts at `dram_addr`; each tile arrives
// over a valid/ready handshake and is written out one byte per cycle.
module store_v #(
    parameter  int TILE_WIDTH = 256,
    parameter  int DATA_WIDTH = 8,
    localparam int ELEM_COUNT = TILE_WIDTH / DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [23:0]           dram_addr,
    input  logic [9:0]            length,
    input  logic [DATA_WIDTH-1:0] tile_in [ELEM_COUNT],
    input  logic                  tile_valid,
    output logic                  tile_ready,
    output logic                  mem_we,
    output logic [23:0]           mem_addr,
    output logic [7:0]            mem_din,
    output logic                  tile_done,
    output logic                  valid_out,
    output logic                  busy
);

    localparam int IDX_W = (ELEM_COUNT > 1) ? $clog2(ELEM_COUNT) : 1;
    localparam int CNT_W = $clog2(ELEM_COUNT + 1);

    // The memory port is byte-wide, so only 8-bit elements make sense.
    if (DATA_WIDTH != 8) begin : g_bad_width
        $fatal(1, "store_v: DATA_WIDTH must be 8");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_TILE,
        S_WRITING,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [23:0]           r_base;
    logic [10:0]           r_len;
    logic [10:0]           r_elem_cnt;   // elements issued so far in this transfer
    logic [CNT_W-1:0]      r_byte_cnt;   // bytes issued so far from the current tile
    logic [DATA_WIDTH-1:0] r_buf [ELEM_COUNT];
    logic                  r_mem_we;
    logic [23:0]           r_mem_addr;
    logic [7:0]            r_mem_din;
    logic                  r_tile_done;
    logic                  r_valid_out;

    logic [23:0]           w_next_addr;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_xfer_last;
    logic                  w_tile_last;

    // 24-bit addition wraps naturally at the top of the address space.
    assign w_next_addr = r_base + {13'd0, r_elem_cnt};
    assign w_idx       = r_byte_cnt[IDX_W-1:0];
    assign w_xfer_last = (r_elem_cnt == r_len);
    assign w_tile_last = (r_byte_cnt == CNT_W'(ELEM_COUNT)) || w_xfer_last;

    // Control FSM and registered memory-port outputs.
    // The first byte of a tile is issued on the handshake edge itself, so
    // mem_we is high exactly in the WRITING cycles and the first write shows
    // up the cycle after the handshake. r_byte_cnt restarts from zero for
    // each tile and already counts that first byte when the tile is accepted.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples the values from before this edge, independent of statement order.
        if (rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_len       <= '0;
            r_elem_cnt  <= '0;
            r_byte_cnt  <= '0;
            // NOTE: the tile buffer is small and is deliberately cleared on
            // reset so no stale tile data survives an abandoned transfer.
            r_buf       <= '{default: '0};
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_tile_done <= 1'b0;
            r_valid_out <= 1'b0;
        end else begin
            r_mem_we    <= 1'b0;
            r_tile_done <= 1'b0;
            r_valid_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_in) begin
                        if (length != 10'd0) begin
                            r_base     <= dram_addr;
                            r_len      <= {1'b0, length};
                            r_elem_cnt <= '0;
                            r_state    <= S_WAIT_TILE;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_WAIT_TILE: begin
                    if (tile_valid) begin
                        r_buf      <= tile_in;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= w_next_addr;
                        r_mem_din  <= tile_in[0];
                        r_byte_cnt <= CNT_W'(1);
                        r_elem_cnt <= r_elem_cnt + 11'd1;
                        r_state    <= S_WRITING;
                    end
                end
                S_WRITING: begin
                    if (w_tile_last) begin
                        r_tile_done <= 1'b1;
                        r_state     <= w_xfer_last ? S_DONE : S_WAIT_TILE;
                    end else begin
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= w_next_addr;
                        r_mem_din  <= r_buf[w_idx];
                        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                        r_elem_cnt <= r_elem_cnt + 11'd1;
                    end
                end
                S_DONE: begin
                    r_valid_out <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tile_ready = (r_state == S_WAIT_TILE);
    assign busy       = (r_state != S_IDLE);
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_din    = r_mem_din;
    assign tile_done  = r_tile_done;
    assign valid_out  = r_valid_out;

endmodule

// File: tb/tb_store_v.sv
// Directed bench for store_v: a monitor logs every byte write and pulse with
// its cycle number; the main sequence compares that log to hand-computed values.
module tb_store_v;

    localparam int EC = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [23:0] dram_addr;
    logic [9:0]  length;
    logic [7:0]  tile_in [EC];
    logic        tile_valid;
    logic        tile_ready;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [7:0]  mem_din;
    logic        tile_done;
    logic        valid_out;
    logic        busy;

    store_v dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .dram_addr  (dram_addr),
        .length     (length),
        .tile_in    (tile_in),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .tile_done  (tile_done),
        .valid_out  (valid_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [23:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        wq[$];
    bit [7:0]   mem [int];
    int         n_tdone, n_vout, n_rdy;
    int         last_tdone_cyc, last_vout_cyc;
    int         n_checks = 0;
    int         n_errors = 0;

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (mem_we === 1'b1) begin
            wq.push_back('{cyc: cyc, addr: mem_addr, data: mem_din});
            mem[int'(mem_addr)] = mem_din;
        end
        if (tile_done === 1'b1) begin
            n_tdone++;
            last_tdone_cyc = cyc;
        end
        if (valid_out === 1'b1) begin
            n_vout++;
            last_vout_cyc = cyc;
        end
        if (tile_ready === 1'b1) n_rdy++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wq.delete();
        n_tdone = 0;
        n_vout  = 0;
        n_rdy   = 0;
        last_tdone_cyc = -1;
        last_vout_cyc  = -1;
    endtask

    // Drives valid_in for one cycle; v is the cycle number while it is high.
    task automatic start(input logic [23:0] a, input logic [9:0] l, output int v);
        @(negedge clk);
        dram_addr = a;
        length    = l;
        valid_in  = 1'b1;
        v         = cyc;
        @(negedge clk);
        valid_in  = 1'b0;
    endtask

    // Waits for tile_ready, stalls, then offers tile seed+i for one cycle.
    // t is the handshake cycle number.
    task automatic send_tile(input string tag, input logic [7:0] seed, input int stall, output int t);
        int n;
        n = 0;
        @(negedge clk);
        while (tile_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready_wait"}, 64'(tile_ready), 64'd1);
        repeat (stall) @(negedge clk);
        for (int i = 0; i < EC; i++) tile_in[i] = seed + 8'(i);
        tile_valid = 1'b1;
        t          = cyc;
        @(negedge clk);
        tile_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int v, v2, t, bad;
        int th[3];
        logic [23:0] wrap_addr [4];

        rst        = 1'b1;
        valid_in   = 1'b0;
        tile_valid = 1'b0;
        dram_addr  = '0;
        length     = '0;
        for (int i = 0; i < EC; i++) tile_in[i] = 8'h00;
        clear_log();

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_outputs", {mem_we, mem_addr, mem_din, tile_done, valid_out, busy, tile_ready}, 64'd0);
        rst = 1'b0;

        // Full 32-element tile, with a stray tile_valid during WRITING.
        clear_log();
        start(24'h000100, 10'd32, v);
        send_tile("t32", 8'h00, 0, t);
        repeat (3) @(negedge clk);
        for (int i = 0; i < EC; i++) tile_in[i] = 8'hEE;
        tile_valid = 1'b1;
        @(negedge clk);
        tile_valid = 1'b0;
        wait_idle("t32", 100);
        chk("t32_write_count", 64'(wq.size()), 64'd32);
        bad = 0;
        for (int i = 0; i < wq.size(); i++)
            if (wq[i].addr !== 24'h100 + 24'(i) || wq[i].data !== 8'(i) || wq[i].cyc != t + 1 + i) bad++;
        chk("t32_write_content", 64'(bad), 64'd0);
        chk("t32_tile_done_count", 64'(n_tdone), 64'd1);
        chk("t32_tile_done_cycle", 64'(last_tdone_cyc), 64'(t + 33));
        chk("t32_valid_out_count", 64'(n_vout), 64'd1);
        chk("t32_valid_out_cycle", 64'(last_vout_cyc), 64'(t + 34));
        chk("t32_hold_outputs", {mem_we, mem_addr, mem_din}, {1'b0, 24'h00011F, 8'h1F});

        // Short transfer: only 5 bytes, neighbours untouched.
        clear_log();
        for (int a = 'h200; a < 'h220; a++) mem[a] = 8'hAA;
        start(24'h000200, 10'd5, v);
        send_tile("t5", 8'h40, 0, t);
        wait_idle("t5", 100);
        chk("t5_write_count", 64'(wq.size()), 64'd5);
        bad = 0;
        for (int i = 0; i < wq.size(); i++)
            if (wq[i].addr !== 24'h200 + 24'(i) || wq[i].data !== 8'h40 + 8'(i) || wq[i].cyc != t + 1 + i) bad++;
        chk("t5_write_content", 64'(bad), 64'd0);
        bad = 0;
        for (int a = 'h205; a < 'h220; a++) if (mem[a] !== 8'hAA) bad++;
        chk("t5_untouched_bytes", 64'(bad), 64'd0);
        chk("t5_tile_done_count", 64'(n_tdone), 64'd1);

        // 70 elements across three tiles, each offered 3 cycles late.
        clear_log();
        start(24'h001000, 10'd70, v);
        send_tile("t70a", 8'd0,  3, th[0]);
        send_tile("t70b", 8'd32, 3, th[1]);
        send_tile("t70c", 8'd64, 3, th[2]);
        wait_idle("t70", 200);
        chk("t70_write_count", 64'(wq.size()), 64'd70);
        bad = 0;
        for (int i = 0; i < wq.size(); i++)
            if (wq[i].addr !== 24'h1000 + 24'(i) || wq[i].data !== 8'(i) ||
                wq[i].cyc != th[i / 32] + 1 + (i % 32)) bad++;
        chk("t70_write_content", 64'(bad), 64'd0);
        chk("t70_tile_done_count", 64'(n_tdone), 64'd3);
        chk("t70_last_tile_done_cycle", 64'(last_tdone_cyc), 64'(th[2] + 7));
        chk("t70_valid_out_count", 64'(n_vout), 64'd1);
        chk("t70_valid_out_cycle", 64'(last_vout_cyc), 64'(th[2] + 8));

        // Zero length, then a back-to-back zero-length start in the IDLE
        // cycle right after DONE.
        clear_log();
        start(24'h000300, 10'd0, v);
        start(24'h000300, 10'd0, v2);
        repeat (4) @(negedge clk);
        chk("len0_back_to_back_slot", 64'(v2), 64'(v + 2));
        chk("len0_tile_ready_cycles", 64'(n_rdy), 64'd0);
        chk("len0_write_count", 64'(wq.size()), 64'd0);
        chk("len0_valid_out_count", 64'(n_vout), 64'd2);
        chk("len0_valid_out_cycle", 64'(last_vout_cyc), 64'(v + 4));

        // Address wrap at the top of the 24-bit space.
        clear_log();
        wrap_addr[0] = 24'hFFFFFE;
        wrap_addr[1] = 24'hFFFFFF;
        wrap_addr[2] = 24'h000000;
        wrap_addr[3] = 24'h000001;
        start(24'hFFFFFE, 10'd4, v);
        send_tile("wrap", 8'h10, 0, t);
        wait_idle("wrap", 100);
        chk("wrap_write_count", 64'(wq.size()), 64'd4);
        bad = 0;
        for (int i = 0; i < wq.size() && i < 4; i++)
            if (wq[i].addr !== wrap_addr[i] || wq[i].data !== 8'h10 + 8'(i)) bad++;
        chk("wrap_write_content", 64'(bad), 64'd0);

        // Reset after the 10th write of a full tile.
        clear_log();
        start(24'h000300, 10'd32, v);
        send_tile("rstw", 8'h80, 0, t);
        repeat (9) @(negedge clk);
        chk("rstw_tenth_write_cycle", 64'(wq.size()), 64'd10);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_outputs_zero", {mem_we, mem_addr, mem_din, tile_done, valid_out, busy, tile_ready}, 64'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("rstw_write_count", 64'(wq.size()), 64'd10);
        chk("rstw_no_pulses", 64'(n_tdone + n_vout), 64'd0);
        chk("rstw_idle", 64'(busy), 64'd0);

        // Normal transfer afterwards, with a valid_in pulse mid-transfer.
        clear_log();
        start(24'h000400, 10'd3, v);
        send_tile("after", 8'h60, 0, t);
        start(24'h000500, 10'd7, v2);
        wait_idle("after", 100);
        repeat (10) @(negedge clk);
        chk("after_write_count", 64'(wq.size()), 64'd3);
        bad = 0;
        for (int i = 0; i < wq.size(); i++)
            if (wq[i].addr !== 24'h400 + 24'(i) || wq[i].data !== 8'h60 + 8'(i)) bad++;
        chk("after_write_content", 64'(bad), 64'd0);
        chk("after_valid_out_count", 64'(n_vout), 64'd1);
        chk("after_stray_start_ignored", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
